// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction width, instruction-memory sizing and
// the encoding returned for fetches that fall outside the stored program.
package mips_pkg;
    localparam int INSTR_W     = 32;
    localparam int IMEM_AW     = 7;
    localparam int FETCH_CNT_W = 16;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and one synchronous read port.
// A read and a write to the same word on the same edge return the old word.
module imem_array #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Non-blocking update keeps the read on the pre-write contents.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/imem_responder.sv
// Memory side of the instruction-fetch interface: valid/ready request, one-cycle
// registered response with backpressure, program-load port and served-fetch count.
module imem_responder
    import mips_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = INSTR_W
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [31:0]            req_addr,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DW-1:0]          resp_data,
    output logic                   resp_err,
    input  logic                   ld_en,
    input  logic [AW-1:0]          ld_addr,
    input  logic [DW-1:0]          ld_data,
    output logic [FETCH_CNT_W-1:0] fetch_cnt
);
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [FETCH_CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic                   accept, consume, in_range;
    logic [DW-1:0]          rd_data;

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;
    assign consume   = resp_valid_q && resp_ready;
    assign in_range  = (req_addr[31:AW] == '0);

    // Storage is only read for in-range accepts, so its output register
    // doubles as the held response data while backpressured.
    imem_array #(
        .AW(AW),
        .DW(DW)
    ) u_array (
        .clk   (clk),
        .we    (ld_en && !res),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (accept && in_range),
        .raddr (req_addr[AW-1:0]),
        .rdata (rd_data)
    );

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        fetch_cnt_d  = fetch_cnt_q;
        if (consume) begin
            resp_valid_d = 1'b0;
            fetch_cnt_d  = fetch_cnt_q + FETCH_CNT_W'(1);
        end
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_err_d   = !in_range;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Storage read register is uninitialised after reset; mask it until a valid in-range response.
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = (resp_valid_q && !resp_err_q) ? rd_data : DW'(NOP_INSTR);
    assign fetch_cnt  = fetch_cnt_q;
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the MIPS processor: the memory side of the instruction-fetch interface driven by the processor's PC/fetch logic. It accepts word-addressed fetch requests over a valid/ready handshake and returns the stored 32-bit instruction one cycle later, with output backpressure. It also provides a program-load write port, used by the button/loader path at bring-up, and a free-running count of served fetches.

## Interface
Parameters
- AW, 7, word-address bits actually stored (DEPTH = 2**AW words)
- DW, 32, instruction width

Ports
- clk  in  1  system clock, all state on rising edge
- res  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept request this cycle
- req_addr  in  32  word address of instruction (PC counts in words, +1 per fetch)
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  fetch side consumes response this cycle
- resp_data  out  DW  instruction word
- resp_err  out  1  request address was out of range
- ld_en  in  1  program-load write strobe
- ld_addr  in  AW  load word address
- ld_data  in  DW  load word
- fetch_cnt  out  16  number of responses consumed, wraps

## Operation
- Request accepted when req_valid && req_ready. req_ready = !resp_valid || resp_ready (single-stage pipeline, full throughput).
- In-range: req_addr[31:AW] == 0 → resp_data = mem[req_addr[AW-1:0]], resp_err = 0.
- Out-of-range: resp_data = NOP (32'h00000000), resp_err = 1; storage not read.
- Response held stable (valid, data, err) while resp_valid && !resp_ready.
- Consumption: resp_valid && resp_ready. If a new request is accepted in the same cycle, the register reloads; otherwise resp_valid clears.
- Load port: ld_en writes ld_data to mem[ld_addr] at the edge; independent of the handshake, never stalls.
- Same-cycle load and accepted read of the same address: read returns OLD contents (read-before-write); the new word is visible from the next request.
- fetch_cnt increments by 1 on every consumption, 16'hFFFF → 16'h0000.
- Storage contents are NOT cleared by res; loaded program survives reset.

## Timing
- Reset values: resp_valid 0, resp_data 0, resp_err 0, fetch_cnt 0; req_ready therefore 1 immediately after reset.
- Latency: request accepted at edge N → resp_valid = 1 with data from edge N onward (visible in cycle N+1).
- Throughput: one fetch per cycle when resp_ready is held high.
- Backpressure: resp_ready low with resp_valid high → req_ready low the same cycle (combinational); no request lost or duplicated.
- res asserted mid-transaction: pending response discarded asynchronously, counter cleared; ld_en during res is ignored.
- req_addr, ld_* sampled only at the rising edge; no combinational path from req_addr to outputs.

## Structure
- Shared package mips_pkg: INSTR_W = 32, IMEM_AW default 7, NOP_INSTR = 32'h00000000, FETCH_CNT_W = 16.
- Sub-module imem_array: DEPTH×DW storage, one synchronous write port (ld_*) and one synchronous read port, read-before-write on collision, no reset. imem_responder holds handshake, range check, output register and counter.

## Test plan
- Load mem[0..3] = 32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000, then stream req_addr 0..3 with resp_ready=1 → four consecutive responses with those words, resp_err 0, one per cycle, fetch_cnt = 4.
- Request addr 5, hold resp_ready=0 for 3 cycles while req_valid=1 addr 6 → req_ready 0, resp_data stable at mem[5]; on release mem[5] then mem[6], no duplicates.
- Request addr 32'h00000080 (AW=7) → resp_data 32'h00000000, resp_err 1; following request addr 1 → resp_err 0.
- Same cycle: ld_en addr 2 data 32'hDEADBEEF and fetch addr 2 (old 32'h01095020) → response 32'h01095020; next fetch addr 2 → 32'hDEADBEEF.
- Assert res with resp_valid=1 and fetch_cnt=10 → resp_valid 0, fetch_cnt 0 immediately; after release, fetch addr 0 still returns the loaded 32'h20080005.
- Consume 65537 responses → fetch_cnt reads 1 (wrap).
